// File: rtl/gps_ca_if_gen_if.sv
// Control/sample bundle for gps_ca_if_gen: tuning words and PRN setup in,
// 2-bit IF sample plus code-phase status out.
interface gps_ca_if_gen_if #(
  parameter int PHASE_W = 32
);
  logic               enable;
  logic               start;
  logic [7:0]         prn;
  logic [9:0]         code_delay;
  logic [PHASE_W-1:0] carr_incr;
  logic [PHASE_W-1:0] code_incr;
  logic signed [2:0]  fe_val;
  logic               fe_valid;
  logic [9:0]         chip_idx;
  logic               epoch_pulse;
  logic [15:0]        epoch_cnt;
  logic               busy;
  logic               err;

  modport master (
    output enable, start, prn, code_delay, carr_incr, code_incr,
    input  fe_val, fe_valid, chip_idx, epoch_pulse, epoch_cnt, busy, err
  );

  modport slave (
    input  enable, start, prn, code_delay, carr_incr, code_incr,
    output fe_val, fe_valid, chip_idx, epoch_pulse, epoch_cnt, busy, err
  );
endinterface

// File: rtl/gps_ca_if_gen.sv
// GPS L1 C/A IF sample source: Gold code x 8-level carrier, NCO-driven.
// Optional additive LFSR noise when GPS_IF_GEN_NOISE_EN is defined.
module gps_ca_if_gen #(
  parameter int          PHASE_W    = 32,
  parameter logic [15:0] NOISE_SEED = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  gps_ca_if_gen_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [9:0] LAST_CHIP = 10'd1022;

  logic [1:0]         state;
  logic [9:0]         g1, g2, g1_adv, g2_adv;
  logic [9:0]         slew;
  logic [3:0]         tap_a, tap_b;
  logic [PHASE_W-1:0] code_acc, carr_acc;
  logic [PHASE_W:0]   code_sum;
  logic [2:0]         ph;
  logic               chip, start_ok, run_en;
  logic signed [2:0]  carr_lvl, samp, fe_next;

  // Packed phase-select taps, each nibble is (stage number - 1).
  function automatic logic [7:0] prn_taps(input logic [7:0] p);
    case (p)
      8'd1:  prn_taps = 8'h15;  8'd2:  prn_taps = 8'h26;
      8'd3:  prn_taps = 8'h37;  8'd4:  prn_taps = 8'h48;
      8'd5:  prn_taps = 8'h08;  8'd6:  prn_taps = 8'h19;
      8'd7:  prn_taps = 8'h07;  8'd8:  prn_taps = 8'h18;
      8'd9:  prn_taps = 8'h29;  8'd10: prn_taps = 8'h12;
      8'd11: prn_taps = 8'h23;  8'd12: prn_taps = 8'h45;
      8'd13: prn_taps = 8'h56;  8'd14: prn_taps = 8'h67;
      8'd15: prn_taps = 8'h78;  8'd16: prn_taps = 8'h89;
      8'd17: prn_taps = 8'h03;  8'd18: prn_taps = 8'h14;
      8'd19: prn_taps = 8'h25;  8'd20: prn_taps = 8'h36;
      8'd21: prn_taps = 8'h47;  8'd22: prn_taps = 8'h58;
      8'd23: prn_taps = 8'h02;  8'd24: prn_taps = 8'h35;
      8'd25: prn_taps = 8'h46;  8'd26: prn_taps = 8'h57;
      8'd27: prn_taps = 8'h68;  8'd28: prn_taps = 8'h79;
      8'd29: prn_taps = 8'h05;  8'd30: prn_taps = 8'h16;
      8'd31: prn_taps = 8'h27;  8'd32: prn_taps = 8'h38;
      default: prn_taps = 8'h15;
    endcase
  endfunction

  always_comb begin
    start_ok = (bus.prn != 8'd0) && (bus.prn <= 8'd32) && (bus.code_delay != 10'd1023);
    run_en   = (state == ST_RUN) && bus.enable && !bus.start;
    g1_adv   = {g1[8:0], g1[2] ^ g1[9]};
    g2_adv   = {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
    chip     = g1[9] ^ g2[tap_a] ^ g2[tap_b];
    code_sum = {1'b0, code_acc} + {1'b0, bus.code_incr};
    // Top three phase bits: magnitude 3 near 0/pi, sign negative for p=2..5.
    ph       = carr_acc[PHASE_W-1 -: 3];
    carr_lvl = (ph[1] == ph[0]) ? 3'sd3 : 3'sd1;
    samp     = ((ph[2] ^ ph[1]) ^ chip) ? -carr_lvl : carr_lvl;
  end

`ifdef GPS_IF_GEN_NOISE_EN
  logic [15:0]       nlfsr;
  logic signed [3:0] nsum;

  always_comb begin
    nsum = $signed({samp[2], samp}) + $signed({nlfsr[2], nlfsr[2:0]});
    if (nsum >= 4'sd2)       fe_next = 3'sd3;
    else if (nsum >= 4'sd0)  fe_next = 3'sd1;
    else if (nsum >= -4'sd2) fe_next = -3'sd1;
    else                     fe_next = -3'sd3;
  end

  always_ff @(posedge clk) begin
    if (rst)
      nlfsr <= NOISE_SEED;
    else if (bus.start && start_ok)
      nlfsr <= NOISE_SEED;
    else if (run_en)
      nlfsr <= {nlfsr[14:0], nlfsr[15] ^ nlfsr[13] ^ nlfsr[12] ^ nlfsr[10]};
  end
`else
  logic unused_seed;
  assign unused_seed = ^NOISE_SEED;
  assign fe_next     = samp;
`endif

  assign bus.busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      g1              <= '1;
      g2              <= '1;
      slew            <= '0;
      tap_a           <= 4'd1;
      tap_b           <= 4'd5;
      code_acc        <= '0;
      carr_acc        <= '0;
      bus.fe_val      <= '0;
      bus.fe_valid    <= 1'b0;
      bus.chip_idx    <= '0;
      bus.epoch_pulse <= 1'b0;
      bus.epoch_cnt   <= '0;
      bus.err         <= 1'b0;
    end else begin
      bus.fe_valid    <= run_en;
      bus.epoch_pulse <= 1'b0;
      if (bus.start) begin
        if (start_ok) begin
          state          <= ST_LOAD;
          {tap_a, tap_b} <= prn_taps(bus.prn);
          slew           <= bus.code_delay;
          g1             <= '1;
          g2             <= '1;
          code_acc       <= '0;
          carr_acc       <= '0;
          bus.chip_idx   <= '0;
          bus.epoch_cnt  <= '0;
          bus.err        <= 1'b0;
        end else begin
          state   <= ST_IDLE;
          bus.err <= 1'b1;
        end
      end else begin
        case (state)
          ST_LOAD: begin
            if (slew != 10'd0) begin
              g1           <= g1_adv;
              g2           <= g2_adv;
              bus.chip_idx <= bus.chip_idx + 10'd1;
              slew         <= slew - 10'd1;
            end else begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.enable) begin
              bus.fe_val <= fe_next;
              code_acc   <= code_sum[PHASE_W-1:0];
              carr_acc   <= carr_acc + bus.carr_incr;
              if (code_sum[PHASE_W]) begin
                // Force the epoch boundary rather than trusting the 1023-chip period.
                if (bus.chip_idx == LAST_CHIP) begin
                  g1              <= '1;
                  g2              <= '1;
                  bus.chip_idx    <= '0;
                  bus.epoch_pulse <= 1'b1;
                  bus.epoch_cnt   <= bus.epoch_cnt + 16'd1;
                end else begin
                  g1           <= g1_adv;
                  g2           <= g2_adv;
                  bus.chip_idx <= bus.chip_idx + 10'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/gps_ca_if_gen.md
# gps_ca_if_gen

Synthesizable GPS L1 C/A IF sample source and the transmit-side counterpart of `gps_ca_correlator_channel`. It produces one 2-bit front-end sample `fe_val` ∈ {+1,+3,−1,−3} per enabled cycle. Each sample is the product of the PRN Gold code, advanced by a code NCO, and an 8-level carrier derived from a carrier NCO. The block is used for loopback self-test of the correlator in FPGA and simulation, replacing file-based stimulus. Its tuning-word semantics are identical to the correlator's `carr_incr` and `code_incr`.

## Interface
- `PHASE_W`, 32: code and carrier NCO accumulator width.
- `NOISE_SEED`, 16'hACE1: noise LFSR load value. Must be nonzero. Used only with the noise feature.

Ports:
- `clk`  in  1  sample clock (16.368 MHz nominal).
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  sample strobe. Active only in RUN.
- `start`  in  1  one-cycle pulse. Latches `prn`/`code_delay` and (re)starts generation.
- `prn`  in  8  satellite PRN; valid range 1..32.
- `code_delay`  in  10  initial code offset in chips; valid range 0..1022.
- `carr_incr`  in  PHASE_W  carrier NCO word; f = incr·fs/2^PHASE_W.
- `code_incr`  in  PHASE_W  code NCO word; chip rate = incr·fs/2^PHASE_W.
- `fe_val`  out  3  signed output sample.
- `fe_valid`  out  1  `fe_val` is valid this cycle.
- `chip_idx`  out  10  index of the current chip, 0..1022.
- `epoch_pulse`  out  1  one-cycle pulse when `chip_idx` wraps 1022→0.
- `epoch_cnt`  out  16  epoch counter; wraps at 2^16.
- `busy`  out  1  asserted in LOAD or RUN.
- `err`  out  1  sticky bad-parameter flag. Cleared by the next valid `start` or by `rst`.

## Operation
- States:
  - IDLE → LOAD on `start` with valid parameters.
  - LOAD → RUN when the slew count reaches 0.
  - Any state → LOAD on a valid `start`, which restarts generation. `start` takes priority over `enable`.
  - Invalid `start` (`prn`==0, `prn`>32, or `code_delay`==1023): set `err`, go to IDLE.
- Gold code generator:
  - G1 = 1+x³+x¹⁰; G2 = 1+x²+x³+x⁶+x⁸+x⁹+x¹⁰; both loaded all-ones on LOAD entry.
  - Chip = G1[10] ^ G2[tapA] ^ G2[tapB], using the standard IS-GPS-200 phase-select table for PRN 1..32 (PRN1 = taps 2,6).
- LOAD:
  - Entry also clears `chip_idx`, both NCO accumulators, and `epoch_cnt`, and reloads the noise LFSR.
  - Slew count is loaded with `code_delay`.
  - Each LOAD cycle with count ≠ 0: advance the code one chip, `chip_idx`++, count−−. No `epoch_pulse` is generated.
  - Count = 0: go to RUN.
- RUN, each cycle with `enable`=1:
  - Sample is formed from the current chip and carrier phase (pre-update values).
  - Then `code_acc` += `code_incr`. On carry-out, advance the code one chip.
  - Then `carr_acc` += `carr_incr`. Wraps modulo 2^PHASE_W.
- Chip advance in RUN:
  - At `chip_idx`==1022: reset G1/G2 to all-ones, set `chip_idx`=0, pulse `epoch_pulse`, `epoch_cnt`++.
  - Otherwise `chip_idx`++.
- Carrier level from p = `carr_acc`[PHASE_W−1:PHASE_W−3], giving c for p = 0..7: +3,+1,−1,−3,−3,−1,+1,+3.
- Sample mapping: chip 0 → s = c; chip 1 → s = −c.

## Timing
- Reset values: `fe_val`=0, `fe_valid`=0, `chip_idx`=0, `epoch_pulse`=0, `epoch_cnt`=0, `busy`=0, `err`=0; state IDLE; LFSRs all-ones.
- `fe_val`/`fe_valid` are registered: a sample is presented the cycle after its enabled RUN cycle.
- `fe_valid`=0 whenever the previous cycle was not an enabled RUN cycle.
- Start latency: `start` at cycle N → LOAD at N+1 → RUN at N+2+`code_delay`.
  - `enable` during IDLE or LOAD is ignored; no sample and no NCO update.
- `epoch_pulse` and the `chip_idx` update are visible the cycle after the carry-producing sample. `epoch_pulse` is aligned with `fe_valid` of that sample.
- `rst` mid-RUN: all outputs return to reset values on the next edge. `err` is cleared.

## Configuration
- `GPS_IF_GEN_NOISE_EN` defined:
  - 16-bit Fibonacci LFSR x¹⁶+x¹⁴+x¹³+x¹¹+1, loaded with `NOISE_SEED` on reset and on LOAD entry.
  - Steps once per enabled RUN cycle.
  - n = lfsr[2:0], interpreted as signed (−4..+3).
  - v = s + n, requantized: v≥2 → +3; 0..1 → +1; −2..−1 → −1; ≤−3 → −3.
- Not defined: `fe_val` = s exactly; no LFSR logic is synthesized.

## Test plan
- Code sequence: PRN1, `code_delay`=0, `carr_incr`=0, `code_incr`=0x8000_0000, noise off, `enable` held high → first 20 `fe_val` = −3,−3,−3,−3,+3,+3,+3,+3,−3,−3, then +3 ×10 (chips 1100100000).
- Epoch timing: same setup → `epoch_pulse` every 2046 valid samples; `epoch_cnt`=3 after 6138 samples.
- Carrier mapping: PRN1, `code_incr`=0, `carr_incr`=0x2000_0000 → `fe_val` repeats −3,−1,+1,+3,+3,+1,−1,−3 (chip 1 inverts c).
- Slew: PRN1, `code_delay`=5 → `busy` high; RUN entered 7 cycles after `start`; `chip_idx`=5 at RUN entry; first chips match PRN1 chips 5..9 (0,0,0,0,0).
- Bad parameters: `start` with `prn`=0, then with `code_delay`=1023 → `err`=1, state IDLE, no `fe_valid`. A valid `start` then clears `err`.
- Reset and restart: `rst` mid-RUN → all outputs return to reset values next cycle. Restarting with identical parameters reproduces an identical sample stream, including noise when `GPS_IF_GEN_NOISE_EN` is defined.
